mem_writer: RTL and testbench
=============================

# mem_writer

Write-side bus engine for the 6502 core; the store-side counterpart of the instruction fetcher. It accepts one write request from the execute stage: a single-byte store, or a 1/2/3-byte stack push for PHA/PHP, JSR, BRK/IRQ/NMI. It sequences the memory write cycles with an ack handshake and returns the updated stack pointer. It sits between the execute/control logic and the shared memory bus, alongside the fetcher's read path.

## Interface
- REG_WIDTH, 8, data/register width
- ADDR_WIDTH, 16, address width
- STACK_PAGE, 8'h01, high address byte of the stack
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_kind  in  2  `WR_STORE=0, `WR_PUSH1=1, `WR_PUSH2=2, `WR_PUSH3=3
- ea  in  ADDR_WIDTH  effective address (STORE only)
- wdata  in  REG_WIDTH  byte for STORE/PUSH1
- pc  in  ADDR_WIDTH  return address (PUSH2/PUSH3)
- status  in  REG_WIDTH  P register (PUSH3); written verbatim, B-flag set by caller
- sp_in  in  REG_WIDTH  current stack pointer
- sp_out  out  REG_WIDTH  updated stack pointer
- sp_we  out  1  1-cycle pulse, push kinds only
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  REG_WIDTH  write data
- mem_we  out  1  write strobe
- mem_ack  in  1  memory accepted current byte (tie 1 for zero-wait)
- busy  out  1  not IDLE
- done  out  1  1-cycle completion pulse

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: req_ready=1. On req_valid, capture kind, ea, wdata, pc, status, sp_in. Set byte counter to 0 and byte count to 1/1/2/3 (STORE/PUSH1/PUSH2/PUSH3). Go to WRITE.
- WRITE: mem_we=1.
  - STORE: mem_addr=ea, mem_wdata=wdata.
  - Push kinds: mem_addr={STACK_PAGE, sp}.
  - Push byte order: PUSH1 wdata; PUSH2 pc[15:8], pc[7:0]; PUSH3 pc[15:8], pc[7:0], status.
- On mem_ack=1 in WRITE:
  - Push kinds: sp decrements by 1, modulo 256, so 8'h00 wraps to 8'hFF; address stays in STACK_PAGE.
  - Counter increments.
  - If the last byte was acked, go to DONE; otherwise stay in WRITE for the next byte.
- mem_ack=0 in WRITE: hold mem_addr, mem_wdata, mem_we stable.
- DONE: done=1. For push kinds, sp_we=1 and sp_out=final sp. Next state IDLE.
- req_valid outside IDLE is ignored; no queueing.
- mem_ack outside WRITE is ignored.

## Timing
- Reset values:
  - state IDLE, req_ready=1, busy=0, done=0, sp_we=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, sp_out=0.
- All outputs are registered.
- Zero-wait latency (accept edge = cycle 0):
  - Bytes are written in cycles 1..N.
  - done in cycle N+1.
  - Next acceptance in cycle N+2.
  - STORE/PUSH1: 3-cycle turnaround. PUSH2: 4. PUSH3: 5.
- Each wait state (mem_ack=0) adds exactly one cycle to the byte in progress.
- sp_out holds its value after DONE until the next push completes.
- reset_n low in any state: IDLE at the next edge, with mem_we=0, no done, no sp_we. Bytes already acked remain in memory; SP is not updated.
- req_kind, ea, wdata, pc, status, sp_in may change after acceptance without effect.

## Structure
- Shared defines header (same one holding the SELECTOR_* and AM3_* constants): WR_STORE, WR_PUSH1, WR_PUSH2, WR_PUSH3 and STACK_PAGE_DEFAULT.
- Single module; no sub-module. The byte-select mux is a case on {kind, counter}.

## Test plan
- STORE, ea=16'h0234, wdata=8'hA5, ack=1 -> cycle 1: mem_addr=0234, mem_wdata=A5, mem_we=1; cycle 2: done=1, sp_we=0; cycle 3: req_ready=1.
- PUSH3, pc=16'hC123, status=8'h34, sp_in=8'hFD -> writes 01FD=C1, 01FC=23, 01FB=34 in cycles 1-3; cycle 4: done=1, sp_we=1, sp_out=FA.
- PUSH2 wrap, pc=16'h8001, sp_in=8'h00 -> writes 0100=80, then 01FF=01; sp_out=FE.
- PUSH1 wdata=8'h5A, sp_in=8'hFF, mem_ack low 3 cycles -> addr 01FF/data 5A/mem_we held 4 cycles; done one cycle after ack; sp_out=FE.
- reset_n low in cycle 2 of PUSH3 (first byte acked) -> next cycle: mem_we=0, busy=0, req_ready=1; no done or sp_we pulse ever.
- req_valid held high with STORE then a second STORE -> second request is ignored while busy and accepted in the first IDLE cycle after DONE; exactly two done pulses.

Source files
------------

// File: rtl/mem_writer_pkg.sv
// Shared types and constants for the write-side bus engine: request kinds,
// FSM states, the default stack page and small per-kind helpers.
package mem_writer_pkg;

  typedef enum logic [1:0] {
    WR_STORE = 2'd0,
    WR_PUSH1 = 2'd1,
    WR_PUSH2 = 2'd2,
    WR_PUSH3 = 2'd3
  } wr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

  function automatic logic kind_is_push(input wr_kind_e kind);
    return (kind != WR_STORE);
  endfunction

  function automatic logic [1:0] kind_nbytes(input wr_kind_e kind);
    logic [1:0] n;
    case (kind)
      WR_PUSH2: n = 2'd2;
      WR_PUSH3: n = 2'd3;
      default:  n = 2'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_writer.sv
// Write-side bus engine: takes one store or 1/2/3-byte stack push, sequences
// the byte writes against mem_ack and reports the updated stack pointer.
module mem_writer
  import mem_writer_pkg::*;
#(
  parameter int                   REG_WIDTH  = 8,
  parameter int                   ADDR_WIDTH = 16,
  parameter logic [REG_WIDTH-1:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_kind,
  input  logic [ADDR_WIDTH-1:0] ea,
  input  logic [REG_WIDTH-1:0]  wdata,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [REG_WIDTH-1:0]  status,
  input  logic [REG_WIDTH-1:0]  sp_in,
  output logic [REG_WIDTH-1:0]  sp_out,
  output logic                  sp_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  // Handshake: a request is taken on a clock edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so requests
  // arriving while busy are simply not taken. A byte completes on an edge
  // where mem_we and mem_ack are both high; until then it is held steady.

  localparam logic [REG_WIDTH-1:0] SP_ONE = REG_WIDTH'(1);

  wr_state_e             state_q, state_d;
  wr_kind_e              kind_q, kind_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [REG_WIDTH-1:0]  wdata_q, wdata_d;
  logic [REG_WIDTH-1:0]  status_q, status_d;
  logic [REG_WIDTH-1:0]  sp_q, sp_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [1:0]            nbytes_q, nbytes_d;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  done_q, done_d;
  logic                  sp_we_q, sp_we_d;
  logic [REG_WIDTH-1:0]  sp_out_q, sp_out_d;
  logic                  req_ready_q, req_ready_d;
  logic                  busy_q, busy_d;

  wr_kind_e              req_kind_e;
  logic                  in_idle;
  wr_kind_e              sel_kind;
  logic [1:0]            sel_cnt;
  logic [ADDR_WIDTH-1:0] sel_pc;
  logic [REG_WIDTH-1:0]  sel_wdata;
  logic [REG_WIDTH-1:0]  sel_status;
  logic [REG_WIDTH-1:0]  sel_sp;
  logic [REG_WIDTH-1:0]  sp_dec;
  logic [REG_WIDTH-1:0]  sel_byte;
  logic [ADDR_WIDTH-1:0] stack_addr;
  logic                  last_byte;

  assign req_kind_e = wr_kind_e'(req_kind);
  assign in_idle    = (state_q == ST_IDLE);
  assign sp_dec     = sp_q - SP_ONE;
  assign last_byte  = (cnt_q == (nbytes_q - 2'd1));

  // The byte being set up next: the first byte of a new request while idle,
  // otherwise the byte following the one just acked.
  always_comb begin
    sel_kind   = in_idle ? req_kind_e : kind_q;
    sel_cnt    = in_idle ? 2'd0 : (cnt_q + 2'd1);
    sel_pc     = in_idle ? pc : pc_q;
    sel_wdata  = in_idle ? wdata : wdata_q;
    sel_status = in_idle ? status : status_q;
    sel_sp     = in_idle ? sp_in : sp_dec;
    stack_addr = ADDR_WIDTH'({STACK_PAGE, sel_sp});
  end

  always_comb begin
    sel_byte = sel_wdata;
    case ({sel_kind, sel_cnt})
      {WR_PUSH2, 2'd0}, {WR_PUSH3, 2'd0}: sel_byte = sel_pc[ADDR_WIDTH-1 -: REG_WIDTH];
      {WR_PUSH2, 2'd1}, {WR_PUSH3, 2'd1}: sel_byte = sel_pc[REG_WIDTH-1:0];
      {WR_PUSH3, 2'd2}:                   sel_byte = sel_status;
      default:                            sel_byte = sel_wdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    ea_d        = ea_q;
    pc_d        = pc_q;
    wdata_d     = wdata_q;
    status_d    = status_q;
    sp_d        = sp_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    sp_out_d    = sp_out_q;
    done_d      = 1'b0;
    sp_we_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d     = ST_WRITE;
          kind_d      = req_kind_e;
          ea_d        = ea;
          pc_d        = pc;
          wdata_d     = wdata;
          status_d    = status;
          sp_d        = sp_in;
          cnt_d       = 2'd0;
          nbytes_d    = kind_nbytes(req_kind_e);
          mem_we_d    = 1'b1;
          mem_addr_d  = kind_is_push(req_kind_e) ? stack_addr : ea;
          mem_wdata_d = sel_byte;
        end
      end

      ST_WRITE: begin
        if (mem_ack) begin
          cnt_d = cnt_q + 2'd1;
          if (kind_is_push(kind_q)) begin
            sp_d = sp_dec;
          end
          if (last_byte) begin
            state_d  = ST_DONE;
            mem_we_d = 1'b0;
            done_d   = 1'b1;
            if (kind_is_push(kind_q)) begin
              sp_we_d  = 1'b1;
              sp_out_d = sp_dec;
            end
          end else begin
            mem_addr_d  = kind_is_push(kind_q) ? stack_addr : ea_q;
            mem_wdata_d = sel_byte;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_we_d = 1'b0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= WR_STORE;
      ea_q        <= '0;
      pc_q        <= '0;
      wdata_q     <= '0;
      status_q    <= '0;
      sp_q        <= '0;
      cnt_q       <= 2'd0;
      nbytes_q    <= 2'd1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      sp_we_q     <= 1'b0;
      sp_out_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      ea_q        <= ea_d;
      pc_q        <= pc_d;
      wdata_q     <= wdata_d;
      status_q    <= status_d;
      sp_q        <= sp_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
      sp_we_q     <= sp_we_d;
      sp_out_q    <= sp_out_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sp_we     = sp_we_q;
  assign sp_out    = sp_out_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_writer.sv
// Directed bench for mem_writer: expected bus writes and completion events
// are queued as requests are issued and checked by an independent monitor.
module tb_mem_writer;
  import mem_writer_pkg::*;

  localparam int W = 27;  // {tag[1:0], addr[15:0], data[7:0], sp_we}

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [15:0] ea;
  logic [7:0]  wdata;
  logic [15:0] pc;
  logic [7:0]  status;
  logic [7:0]  sp_in;
  logic [7:0]  sp_out;
  logic        sp_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;
  int done_cnt;

  mem_writer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .ea        (ea),
    .wdata     (wdata),
    .pc        (pc),
    .status    (status),
    .sp_in     (sp_in),
    .sp_out    (sp_out),
    .sp_we     (sp_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_wr(input logic [15:0] a, input logic [7:0] d);
    return {2'd1, a, d, 1'b0};
  endfunction

  function automatic logic [W-1:0] exp_done(input logic [7:0] sp, input logic we);
    return {2'd2, 16'h0000, sp, we};
  endfunction

  task automatic sb_compare(input string name, input logic [W-1:0] act);
    logic [W-1:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_%s: act=%h req=<nothing expected>", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL sb_%s: act=%h req=%h", name, act, exp);
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n) begin
        if (mem_we && mem_ack) sb_compare("write", exp_wr(mem_addr, mem_wdata));
        if (done) begin
          done_cnt++;
          sb_compare("done", exp_done(sp_out, sp_we));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at the falling edge in cycle 1 (the request was taken on the
  // rising edge just before it).
  task automatic issue(input logic [1:0] kind, input logic [15:0] a, input logic [7:0] d,
                       input logic [15:0] p, input logic [7:0] st, input logic [7:0] sp,
                       input logic ack, input logic keep);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", {31'd0, req_ready}, 32'd1);
    req_kind  = kind;
    ea        = a;
    wdata     = d;
    pc        = p;
    status    = st;
    sp_in     = sp;
    mem_ack   = ack;
    req_valid = 1'b1;
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    req_kind = 2'd0;
    ea       = 16'hDEAD;
    pc       = 16'hBEEF;
    wdata    = 8'hEE;
    status   = 8'hEE;
    sp_in    = 8'h77;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("wait_idle_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    done_cnt  = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_kind  = 2'd0;
    ea        = 16'h0000;
    wdata     = 8'h00;
    pc        = 16'h0000;
    status    = 8'h00;
    sp_in     = 8'h00;
    mem_ack   = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_sp_we",     {31'd0, sp_we},     32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_sp_out",    {24'd0, sp_out},    32'd0);
    reset_n = 1'b1;

    // STORE, zero-wait: 3-cycle turnaround, sp_out untouched
    exp_q.push_back(exp_wr(16'h0234, 8'hA5));
    exp_q.push_back(exp_done(8'h00, 1'b0));
    issue(WR_STORE, 16'h0234, 8'hA5, 16'h0000, 8'h00, 8'h42, 1'b1, 1'b0);
    check("store_c1_we_addr_data", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h0234, 8'hA5});
    check("store_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("store_c2_done", {30'd0, done, sp_we}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    check("store_c3_ready", {31'd0, req_ready}, 32'd1);

    // PUSH3: pc hi, pc lo, status; done in cycle 4
    exp_q.push_back(exp_wr(16'h01FD, 8'hC1));
    exp_q.push_back(exp_wr(16'h01FC, 8'h23));
    exp_q.push_back(exp_wr(16'h01FB, 8'h34));
    exp_q.push_back(exp_done(8'hFA, 1'b1));
    issue(WR_PUSH3, 16'h0000, 8'h00, 16'hC123, 8'h34, 8'hFD, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("push3_c4_done", {30'd0, done, sp_we}, {30'd0, 1'b1, 1'b1});
    check("push3_c4_sp_out", {24'd0, sp_out}, {24'd0, 8'hFA});
    @(negedge clk);
    check("push3_c5_ready", {31'd0, req_ready}, 32'd1);

    // PUSH2 with SP wrapping from 00 to FF inside the stack page
    exp_q.push_back(exp_wr(16'h0100, 8'h80));
    exp_q.push_back(exp_wr(16'h01FF, 8'h01));
    exp_q.push_back(exp_done(8'hFE, 1'b1));
    issue(WR_PUSH2, 16'h0000, 8'h00, 16'h8001, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_idle();
    check("push2_sp_out_hold", {24'd0, sp_out}, {24'd0, 8'hFE});

    // PUSH1 with three wait states: byte held for four cycles
    exp_q.push_back(exp_wr(16'h01FF, 8'h5A));
    exp_q.push_back(exp_done(8'hFE, 1'b1));
    issue(WR_PUSH1, 16'h0000, 8'h5A, 16'h0000, 8'h00, 8'hFF, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) mem_ack = 1'b1;
      check($sformatf("push1_hold_c%0d", k), {7'd0, mem_we, mem_addr, mem_wdata},
            {7'd0, 1'b1, 16'h01FF, 8'h5A});
      @(negedge clk);
    end
    check("push1_c5_done", {30'd0, done, sp_we}, {30'd0, 1'b1, 1'b1});
    check("push1_c5_sp_out", {24'd0, sp_out}, {24'd0, 8'hFE});
    wait_idle();

    // Reset during the second byte of a PUSH3: no done, no sp_we
    exp_q.push_back(exp_wr(16'h0180, 8'h12));
    issue(WR_PUSH3, 16'h0000, 8'h00, 16'h1234, 8'h30, 8'h80, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_mid_c2_we", {31'd0, mem_we}, 32'd1);
    reset_n = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rst_mid_c3_we_busy_ready", {29'd0, mem_we, busy, req_ready}, {29'd0, 3'b001});
    check("rst_mid_c3_sp_we_done", {30'd0, sp_we, done}, 32'd0);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    repeat (8) @(negedge clk);

    // Back-to-back STOREs with req_valid held: second taken after DONE
    exp_q.push_back(exp_wr(16'h0300, 8'h11));
    exp_q.push_back(exp_done(8'h00, 1'b0));
    exp_q.push_back(exp_wr(16'h0301, 8'h22));
    exp_q.push_back(exp_done(8'h00, 1'b0));
    issue(WR_STORE, 16'h0300, 8'h11, 16'h0000, 8'h00, 8'h00, 1'b1, 1'b1);
    req_kind = WR_STORE;
    ea       = 16'h0301;
    wdata    = 8'h22;
    @(negedge clk);
    check("b2b_c2_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_c3_ready_we", {30'd0, req_ready, mem_we}, {30'd0, 1'b1, 1'b0});
    @(negedge clk);
    check("b2b_c4_second_write", {15'd0, mem_we, mem_addr}, {15'd0, 1'b1, 16'h0301});
    req_valid = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);

    check("sb_queue_drained", exp_q.size(), 32'd0);
    check("done_pulse_count", done_cnt, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
